// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Each frame is
//                start(0), 8 data bits LSB first, parity, stop(1).
//                Bit timing comes from an internal bit-period counter on the
//                system clock. There is no derived baud clock.
//                Each good byte is presented with a one-cycle rx_valid strobe
//                and a parity_err flag. A low stop bit gives a one-cycle
//                frame_err pulse and the byte is discarded.
//  Ports       : clk        - system clock, the single clock of the block
//                reset      - synchronous, active-high reset
//                rx         - asynchronous serial input, idles high
//                data_rx    - last good byte; holds until the next good frame
//                rx_valid   - one-cycle pulse: data_rx updated this cycle
//                parity_err - valid with rx_valid: parity bit mismatched
//                frame_err  - one-cycle pulse: stop bit sampled low
//                rx_busy    - high from start-bit detection until back in IDLE
//  Parameters  : BAUD_DIV   - clk cycles per bit (>= 4)
//                PARITY     - 0 = even, 1 = odd
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_DIV = 6,
    parameter bit PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_CW   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    // HALF is the counter value at the middle of the start bit.
    localparam logic [c_CW-1:0] c_HALF = c_CW'(BAUD_DIV / 2 - 1);
    // LAST is the counter value one full bit period after the previous sample.
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BAUD_DIV - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shreg;
    logic            r_perr;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_perr_flag;
    logic            r_ferr;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      w_shreg_nxt;
    logic            w_perr_nxt;
    logic [7:0]      w_data_nxt;
    logic            w_valid_nxt;
    logic            w_perr_flag_nxt;
    logic            w_ferr_nxt;
    logic            w_rxs;
    logic            w_tick;

    // Synchronised serial input. Every decision uses this signal only.
    assign w_rxs  = r_sync2;

    // One full bit period has passed since the previous sample point.
    assign w_tick = (r_cnt == c_LAST);

    // ------------------------------------------------------------------------
    // Two-stage input synchroniser
    // ------------------------------------------------------------------------
    // Both stages reset high so the idle line does not look like a start bit
    // in the first cycles after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_perr      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr_flag <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_perr      <= w_perr_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_perr_flag <= w_perr_flag_nxt;
            r_ferr      <= w_ferr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    // After the start bit, r_cnt is cleared at each sample point. Each later
    // sample is therefore taken exactly BAUD_DIV cycles after the previous
    // one, and every sample stays aligned to the middle of its bit.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_idx_nxt       = r_idx;
        w_shreg_nxt     = r_shreg;
        w_perr_nxt      = r_perr;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_perr_flag_nxt = 1'b0;
        w_ferr_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt = '0;
                    if (!w_rxs) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        // The line went high again before mid-bit.
                        // Treat it as a glitch and drop it without any flag.
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt          = '0;
                    w_shreg_nxt[r_idx] = w_rxs;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = w_rxs ^ PARITY ^ (^r_shreg);
                    w_state_nxt = S_STOP;
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_data_nxt      = r_shreg;
                        w_valid_nxt     = 1'b1;
                        w_perr_flag_nxt = r_perr;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        // Framing error. data_rx keeps its old value. Wait
                        // for the line to return high so that a break is not
                        // decoded as a run of 0x00 frames.
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end

            S_WAIT_HI: begin
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_rx    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_flag;
    assign frame_err  = r_ferr;
    assign rx_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (BAUD_DIV=6, PARITY=0).
//                The stimulus side turns each byte into a serial waveform and
//                also queues the outcome that byte must produce: either a
//                good byte with its parity flag, or a framing error. It also
//                queues the cycle window in which that outcome must appear.
//                A single compare process checks the DUT outputs against the
//                queue and against the held byte on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int B    = 6;
    localparam bit PAR  = 1'b0;
    localparam int HALF = B / 2 - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_rx;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.BAUD_DIV(B), .PARITY(PAR)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_ferr;
        logic [7:0] d;
        bit         perr;
        int         lo;
        int         hi;
    } ev_t;

    ev_t        q[$];
    int         errors   = 0;
    int         checks   = 0;
    logic [7:0] exp_hold = 8'h00;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    logic [7:0] last_d   = 8'h00;
    bit         last_perr = 1'b0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        ev_t e;
        if (reset !== 1'b1) begin
            if (rx_valid || frame_err) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("strobe_valid", rx_valid, !e.is_ferr);
                    check_eq("strobe_ferr", frame_err, e.is_ferr);
                    check_eq("strobe_in_window", (cyc >= e.lo && cyc <= e.hi), 1);
                    if (!e.is_ferr) begin
                        check_eq("data_rx", data_rx, e.d);
                        check_eq("parity_err", parity_err, e.perr);
                        exp_hold  = e.d;
                        last_d    = data_rx;
                        last_perr = parity_err;
                        n_valid++;
                    end else begin
                        check_eq("data_hold_on_ferr", data_rx, exp_hold);
                        check_eq("parity_err_on_ferr", parity_err, 0);
                        n_ferr++;
                    end
                end
            end else begin
                check_eq("data_hold", data_rx, exp_hold);
                check_eq("parity_err_idle", parity_err, 0);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame and queues its expected outcome. The stop bit is
    // sampled mid-bit, i.e. in bit slot 10 of the frame, so the strobe must
    // fall within the stop bit plus a little pipeline slack.
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit stop_v, input int low_extra);
        logic p;
        ev_t  e;
        p         = PAR ^ (^d) ^ bad_par;
        e.is_ferr = !stop_v;
        e.d       = d;
        e.perr    = p ^ PAR ^ (^d);
        e.lo      = cyc + 10 * B;
        e.hi      = cyc + 11 * B + 2;
        q.push_back(e);
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(d[i], B);
        hold(p, B);
        hold(stop_v, B);
        if (!stop_v) begin
            hold(1'b0, low_extra * B);
            hold(1'b1, B);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(name, q.size(), 0);
        hold(1'b1, 3);
    endtask

    initial begin
        int nv0;
        int nf0;
        int k;
        bit seen_busy;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_data_rx", data_rx, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_parity_err", parity_err, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_rx_busy", rx_busy, 0);
        @(posedge clk);
        #1;
        hold(1'b1, 2 * B);

        // 1. clean 0xA5
        nv0 = n_valid;
        send_frame(8'hA5, 0, 1, 0);
        drain("t1_drain");
        check_eq("t1_count", n_valid - nv0, 1);
        check_eq("t1_data", data_rx, 8'hA5);
        check_eq("t1_perr", last_perr, 0);
        check_eq("t1_idle_busy", rx_busy, 0);

        // 2. 0x01 with parity bit 0 (even parity needs 1)
        send_frame(8'h01, 1, 1, 0);
        drain("t2_drain");
        check_eq("t2_data", last_d, 8'h01);
        check_eq("t2_perr", last_perr, 1);

        // 3. 0x3C with a low stop bit, line held low for 20 bit times
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h3C, 0, 0, 20);
        drain("t3_drain");
        check_eq("t3_ferr_count", n_ferr - nf0, 1);
        check_eq("t3_no_valid", n_valid - nv0, 0);
        check_eq("t3_data_kept", data_rx, 8'h01);
        send_frame(8'h55, 0, 1, 0);
        drain("t3b_drain");
        check_eq("t3b_data", data_rx, 8'h55);

        // 4. two-cycle glitch
        nv0 = n_valid;
        nf0 = n_ferr;
        k   = cyc;
        seen_busy = 1'b0;
        hold(1'b0, 2);
        rx = 1'b1;
        while (cyc < k + HALF + 6) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        @(negedge clk);
        check_eq("t4_busy_seen", seen_busy, 1);
        check_eq("t4_busy_cleared", rx_busy, 0);
        hold(1'b1, 3 * B);
        check_eq("t4_no_strobe", (n_valid - nv0) + (n_ferr - nf0), 0);

        // 5. back-to-back, zero idle bits
        nv0 = n_valid;
        send_frame(8'h00, 0, 1, 0);
        send_frame(8'hFF, 0, 1, 0);
        send_frame(8'h81, 0, 1, 0);
        drain("t5_drain");
        check_eq("t5_count", n_valid - nv0, 3);
        check_eq("t5_last", data_rx, 8'h81);

        // 6. reset during data bit 4 of 0xC3, then a clean 0x5A
        nv0 = n_valid;
        hold(1'b0, B);
        for (int i = 0; i < 4; i++) hold(k[0] ^ k[0] ^ (8'hC3 >> i) & 1'b1, B);
        hold(1'b0, B / 2);
        reset    = 1'b1;
        rx       = 1'b1;
        exp_hold = 8'h00;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_data", data_rx, 8'h00);
        check_eq("t6_rst_busy", rx_busy, 0);
        @(posedge clk);
        #1;
        hold(1'b1, 12 * B);
        check_eq("t6_no_strobe", n_valid - nv0, 0);
        send_frame(8'h5A, 0, 1, 0);
        drain("t6_drain");
        check_eq("t6_data", data_rx, 8'h5A);

        // Random traffic with random gaps, parity faults and framing faults.
        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0), $urandom_range(0, 3));
            hold(1'b1, $urandom_range(0, 2) * B + $urandom_range(0, 2));
        end
        drain("rand_drain");
        check_eq("rand_idle_busy", rx_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected < 60000", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
